// File: rtl/pe_pkg.sv
// pe_pkg: shared saturation bounds, overflow test and width check for the systolic PE
//   MAX_BW           widest accumulator the helpers support
//   sat_max/sat_min  clamp limits for a bw-bit accumulator, signed or unsigned
//   add_ovf          overflow of a BW-bit add from the addend/sum sign bits and carry-out
//   PE_CHECK_WIDTHS  elaboration guard: 2*DATA_WIDTH <= BUS_WIDTH <= MAX_BW
`define PE_CHECK_WIDTHS(dw, bw) \
  if ((bw) < 2 * (dw) || (bw) > pe_pkg::MAX_BW) begin : g_bad_widths \
    $error("pe_mac_cell: BUS_WIDTH must lie in [2*DATA_WIDTH, 64]"); \
  end
package pe_pkg;
  localparam int MAX_BW = 64;
  function automatic logic [MAX_BW-1:0] sat_max(input int bw, input logic sgn);
    return {MAX_BW{1'b1}} >> (MAX_BW - bw + int'(sgn));
  endfunction
  function automatic logic [MAX_BW-1:0] sat_min(input int bw, input logic sgn);
    return sgn ? {MAX_BW{1'b1}} << (bw - 1) : '0;
  endfunction
  function automatic logic add_ovf(input logic a_msb, b_msb, s_msb, cout, sgn);
    return sgn ? (a_msb == b_msb) && (s_msb != a_msb) : cout;
  endfunction
endpackage

// File: rtl/pe_mac_cell_if.sv
// pe_mac_cell_if: operand/result bundle between a PE and its neighbours
//   _i signals flow into the PE (clr, valid, signed mode, north/west operands)
//   _o signals flow out (south/east forwarded operands, valid, accumulator, overflow flag)
//   slave: the PE side; master: the driver side
interface pe_mac_cell_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
);
  logic                  clr_i, valid_i, signed_i;
  logic [DATA_WIDTH-1:0] north_i, west_i, south_o, east_o;
  logic                  valid_o, ouflow_o;
  logic [BUS_WIDTH-1:0]  res_o;
  modport master (
    output clr_i, valid_i, signed_i, north_i, west_i,
    input  south_o, east_o, valid_o, res_o, ouflow_o
  );
  modport slave (
    input  clr_i, valid_i, signed_i, north_i, west_i,
    output south_o, east_o, valid_o, res_o, ouflow_o
  );
endinterface

// File: rtl/pe_mult_stage.sv
// pe_mult_stage: signed/unsigned DATA_WIDTH multiplier, extended to BUS_WIDTH, optionally registered
//   clk_i, rst_ni          clock, async active-low reset
//   valid_i, signed_i      operand pair valid and its number format
//   a_i, b_i               operands
//   valid_o, signed_o      product valid and format, aligned with prod_o
//   prod_o                 product sign/zero-extended to BUS_WIDTH
module pe_mult_stage
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int MUL_PIPE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  output logic                  signed_o,
  output logic [BUS_WIDTH-1:0]  prod_o
);
  localparam int PW = 2 * DATA_WIDTH;
  logic [PW-1:0]        a_x, b_x, p;
  logic [BUS_WIDTH-1:0] p_sx, p_zx, prod_d;
  // Operands are extended to the full product width first, so the low PW bits
  // of one unsigned multiply are correct for both number formats.
  always_comb begin
    a_x    = {{DATA_WIDTH{signed_i & a_i[DATA_WIDTH-1]}}, a_i};
    b_x    = {{DATA_WIDTH{signed_i & b_i[DATA_WIDTH-1]}}, b_i};
    p      = a_x * b_x;
    p_sx   = BUS_WIDTH'($signed(p));
    p_zx   = BUS_WIDTH'(p);
    prod_d = signed_i ? p_sx : p_zx;
  end
  if (MUL_PIPE != 0) begin : g_pipe
    logic                 valid_q, signed_q;
    logic [BUS_WIDTH-1:0] prod_q;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        valid_q  <= 1'b0;
        signed_q <= 1'b0;
        prod_q   <= '0;
      end else begin
        valid_q  <= valid_i;
        signed_q <= signed_i;
        prod_q   <= prod_d;
      end
    assign valid_o  = valid_q;
    assign signed_o = signed_q;
    assign prod_o   = prod_q;
  end else begin : g_comb
    assign valid_o  = valid_i;
    assign signed_o = signed_i;
    assign prod_o   = prod_d;
  end
endmodule

// File: rtl/pe_mac_cell.sv
// pe_mac_cell: systolic PE forwarding north->south / west->east and accumulating their products
//   clk_i, rst_ni  clock, async active-low reset
//   bus (slave)    clr/valid/signed/north/west in; south/east/valid/res/ouflow out
//   SAT_EN         1: clamp on overflow, 0: wrap
//   MUL_PIPE       1: registered product stage (result latency 2)
module pe_mac_cell
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int SAT_EN     = 0,
  parameter int MUL_PIPE   = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pe_mac_cell_if.slave bus
);
  `PE_CHECK_WIDTHS(DATA_WIDTH, BUS_WIDTH)
  // Without a product stage, a term arriving with clr_i is visible at once and
  // becomes the first accumulator value; with one, it is still in the stage.
  localparam bit LOAD_ON_CLR = (MUL_PIPE == 0);
  logic [DATA_WIDTH-1:0] south_q, south_d, east_q, east_d;
  logic                  valid_q, ouflow_q, ouflow_d;
  logic [BUS_WIDTH-1:0]  acc_q, acc_d, prod, sat_val;
  logic [BUS_WIDTH:0]    sum;
  logic                  p_valid, p_sgn, ovf;
  pe_mult_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .MUL_PIPE  (MUL_PIPE)
  ) u_mult (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (bus.valid_i),
    .signed_i(bus.signed_i),
    .a_i     (bus.north_i),
    .b_i     (bus.west_i),
    .valid_o (p_valid),
    .signed_o(p_sgn),
    .prod_o  (prod)
  );
  always_comb begin
    south_d  = bus.valid_i ? bus.north_i : south_q;
    east_d   = bus.valid_i ? bus.west_i : east_q;
    sum      = {1'b0, acc_q} + {1'b0, prod};
    ovf      = add_ovf(acc_q[BUS_WIDTH-1], prod[BUS_WIDTH-1], sum[BUS_WIDTH-1], sum[BUS_WIDTH], p_sgn);
    // A signed overflow has both addends of equal sign, so the accumulator sign picks the rail.
    sat_val  = (p_sgn && acc_q[BUS_WIDTH-1]) ? BUS_WIDTH'(sat_min(BUS_WIDTH, 1'b1))
                                             : BUS_WIDTH'(sat_max(BUS_WIDTH, p_sgn));
    acc_d    = bus.clr_i ? ((LOAD_ON_CLR && p_valid) ? prod : '0) :
               !p_valid ? acc_q :
               (SAT_EN != 0 && ovf) ? sat_val : sum[BUS_WIDTH-1:0];
    ouflow_d = !bus.clr_i && (ouflow_q || (p_valid && ovf));
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      south_q  <= '0;
      east_q   <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      ouflow_q <= 1'b0;
    end else begin
      south_q  <= south_d;
      east_q   <= east_d;
      valid_q  <= bus.valid_i;
      acc_q    <= acc_d;
      ouflow_q <= ouflow_d;
    end
  assign bus.south_o  = south_q;
  assign bus.east_o   = east_q;
  assign bus.valid_o  = valid_q;
  assign bus.res_o    = acc_q;
  assign bus.ouflow_o = ouflow_q;
endmodule

// File: tb/tb_pe_mac_cell.sv
// tb_pe_mac_cell: four PE variants (32b/16b, wrap/saturate, MUL_PIPE 0/1) driven in lockstep
module tb_pe_mac_cell;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 1'b0, valid = 1'b0, sgn = 1'b0;
  logic [7:0] north = '0, west = '0;
  logic [3:0][31:0] res;
  logic [3:0][7:0]  so, eo;
  logic [3:0]       ouf, vo;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  // 0: BW32 wrap MP0, 1: BW32 wrap MP1, 2: BW16 wrap MP0, 3: BW16 sat MP1
  for (genvar g = 0; g < 4; g++) begin : g_pe
    localparam int BW = g < 2 ? 32 : 16;
    pe_mac_cell_if #(.DATA_WIDTH(8), .BUS_WIDTH(BW)) bus ();
    assign bus.clr_i    = clr;
    assign bus.valid_i  = valid;
    assign bus.signed_i = sgn;
    assign bus.north_i  = north;
    assign bus.west_i   = west;
    pe_mac_cell #(.DATA_WIDTH(8), .BUS_WIDTH(BW), .SAT_EN(g == 3 ? 1 : 0), .MUL_PIPE(g % 2)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
    );
    assign res[g] = 32'(bus.res_o);
    assign so[g]  = bus.south_o;
    assign eo[g]  = bus.east_o;
    assign vo[g]  = bus.valid_o;
    assign ouf[g] = bus.ouflow_o;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_res(input string tag, input logic [31:0] e0, e1, e2, e3);
    chk({tag, "_res"}, res, {e3, e2, e1, e0});
  endtask
  task automatic chk_fwd(input string tag, input logic [7:0] n, w, input logic v);
    chk({tag, "_fwd"}, {so, eo, vo}, {{4{n}}, {4{w}}, {4{v}}});
  endtask
  task automatic step(input logic c, v, s, input logic [7:0] nn, ww);
    clr = c; valid = v; sgn = s; north = nn; west = ww;
    @(negedge clk);
  endtask
  task automatic run_t1(input string tag);
    step(0, 1, 0, 8'd1, 8'd2);
    chk_res({tag, "_lat"}, 2, 0, 2, 0);
    chk_fwd({tag, "_first"}, 1, 2, 1);
    step(0, 1, 0, 8'd3, 8'd4);
    chk_fwd({tag, "_second"}, 3, 4, 1);
    step(0, 1, 0, 8'd5, 8'd6);
    step(0, 1, 0, 8'd7, 8'd8);
    step(0, 0, 0, 8'h55, 8'h66);
    step(0, 0, 0, 8'h55, 8'h66);
    chk_res(tag, 100, 100, 100, 100);
    chk_fwd({tag, "_hold"}, 7, 8, 0);
    chk({tag, "_ouf"}, ouf, 4'b0000);
  endtask
  initial begin
    @(negedge clk);
    chk_res("reset", 0, 0, 0, 0);
    chk_fwd("reset", 0, 0, 0);
    chk("reset_ouf", ouf, 4'b0000);
    rst_n = 1'b1;
    run_t1("t1");
    step(1, 0, 0, 0, 0);
    chk_res("t2_clr", 0, 0, 0, 0);
    step(0, 1, 0, 8'd11, 8'd22);
    step(0, 1, 0, 8'd33, 8'd44);
    step(0, 1, 0, 8'd55, 8'd66);
    step(0, 1, 0, 8'd77, 8'd88);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_res("t2", 12100, 12100, 12100, 12100);
    step(1, 1, 0, 8'd11, 8'd22);
    chk_res("t2_clrload", 242, 0, 242, 0);
    step(0, 1, 0, 8'd33, 8'd44);
    step(0, 1, 0, 8'd55, 8'd66);
    step(0, 1, 0, 8'd77, 8'd88);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_res("t2_reload", 12100, 12100, 12100, 12100);
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 8'hFF, 8'd2);
    step(0, 0, 1, 8'hAA, 8'hBB);
    chk_fwd("t3_gap", 8'hFF, 8'd2, 0);
    step(0, 1, 1, 8'hFD, 8'd4);
    step(0, 0, 1, 8'hAA, 8'hBB);
    chk_fwd("t3_gap2", 8'hFD, 8'd4, 0);
    step(0, 1, 1, 8'hFB, 8'd6);
    step(0, 1, 1, 8'hF9, 8'd8);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_res("t3", 32'hFFFFFF9C, 32'hFFFFFF9C, 32'h0000FF9C, 32'h0000FF9C);
    chk("t3_ouf", ouf, 4'b0000);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 8'd255, 8'd255);
    step(0, 1, 0, 8'd255, 8'd255);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_res("t4", 32'h0001FC02, 32'h0001FC02, 32'h0000FC02, 32'h0000FFFF);
    chk("t4_ouf", ouf, 4'b1100);
    step(0, 0, 0, 0, 0);
    chk("t4_sticky", ouf, 4'b1100);
    step(1, 0, 1, 0, 0);
    chk("t5_clr_ouf", ouf, 4'b0000);
    step(0, 1, 1, 8'h80, 8'h7F);
    step(0, 1, 1, 8'h80, 8'h7F);
    step(0, 1, 1, 8'h80, 8'h7F);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_res("t5", 32'hFFFF4180, 32'hFFFF4180, 32'h00004180, 32'h00008000);
    chk("t5_ouf", ouf, 4'b1100);
    step(1, 0, 0, 0, 0);
    chk_res("t5_clr", 0, 0, 0, 0);
    chk("t5_clr_ouf", ouf, 4'b0000);
    step(0, 1, 0, 8'd1, 8'd2);
    step(0, 1, 0, 8'd3, 8'd4);
    chk_res("t6_pre", 14, 2, 14, 2);
    #3 rst_n = 1'b0;
    #1;
    chk_res("t6_async", 0, 0, 0, 0);
    chk_fwd("t6_async", 0, 0, 0);
    chk("t6_async_ouf", ouf, 4'b0000);
    clr = 0; valid = 0; north = 0; west = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_t1("t6");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
